// File: rtl/data_memory_dump_unit.sv
// -----------------------------------------------------------------------------
// data_memory_dump_unit
//
// Debug-side reader that sweeps the whole data memory and streams it to the
// debug UART transmitter.
//
// A start pulse in IDLE begins a sweep of addresses 0..RAM_DEPTH-1. Each word
// is read in one cycle. The memory read data is combinational, so it is
// captured in the same cycle that the read is issued. The word is then sent
// one byte at a time, most-significant byte first. Each byte uses a
// tx_start / tx_done handshake with the UART.
//
// Ports
//   i_clock         system clock; all logic is on the rising edge
//   i_reset         synchronous, active-high reset
//   i_start         dump request; only looked at in IDLE
//   o_read_enable   read enable to the data memory (READ state only)
//   o_read_address  word address to the data memory (address counter)
//   i_mem_data      combinational memory read data
//   o_tx_data       byte presented to the UART TX (top byte of shift register)
//   o_tx_start      one-cycle pulse that starts a byte transmit
//   i_tx_done       UART TX finished the current byte (only looked at in WAIT)
//   o_busy          high in every state except IDLE
//   o_done          one-cycle pulse when the dump completes
// -----------------------------------------------------------------------------
module data_memory_dump_unit #(
    parameter int NB_ADDR   = 32,
    parameter int NB_DATA   = 32,
    parameter int RAM_DEPTH = 32,
    parameter int NB_BYTE   = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_read_enable,
    output logic [NB_ADDR-1:0] o_read_address,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_BYTE_CNT    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [NB_BYTE_CNT-1:0] LAST_BYTE = NB_BYTE_CNT'(BYTES_PER_WORD - 1);
    localparam logic [NB_ADDR-1:0]     LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        WAIT,
        NEXT,
        DONE
    } state_t;

    state_t                 state;
    logic [NB_ADDR-1:0]     address;
    logic [NB_BYTE_CNT-1:0] byte_count;
    logic [NB_DATA-1:0]     shift_reg;

    // The top byte of the shift register is always the byte on the wire.
    // Shifting left after each byte therefore gives MSB-first order.
    assign o_tx_data      = shift_reg[NB_DATA-1 -: NB_BYTE];
    assign o_read_address = address;

    // All outputs are registered. They are set on the edge that enters the
    // state in which they must be high.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: the shift register is reset along with the control state.
            // o_tx_data is taken directly from it and must read 0 after reset.
            state         <= IDLE;
            address       <= '0;
            byte_count    <= '0;
            shift_reg     <= '0;
            o_read_enable <= 1'b0;
            o_tx_start    <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            // NOTE: the pulse outputs default low on every edge, so each one
            // is high only for the single cycle whose branch sets it below.
            // All state here uses non-blocking assignment. Every branch then
            // sees the values from before this edge.
            o_read_enable <= 1'b0;
            o_tx_start    <= 1'b0;
            o_done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state         <= READ;
                        address       <= '0;
                        o_read_enable <= 1'b1;
                        o_busy        <= 1'b1;
                    end
                end

                // The read data is combinational, so the word is captured in
                // the same cycle that the read is enabled.
                READ: begin
                    shift_reg  <= i_mem_data;
                    byte_count <= '0;
                    state      <= SEND;
                    o_tx_start <= 1'b1;
                end

                SEND: begin
                    state <= WAIT;
                end

                // i_tx_done counts only here. A stray pulse in any other state
                // cannot advance the byte stream.
                WAIT: begin
                    if (i_tx_done) begin
                        if (byte_count == LAST_BYTE) begin
                            state <= NEXT;
                        end else begin
                            shift_reg  <= shift_reg << NB_BYTE;
                            byte_count <= byte_count + NB_BYTE_CNT'(1);
                            state      <= SEND;
                            o_tx_start <= 1'b1;
                        end
                    end
                end

                // The sweep ends on equality, so the address never wraps.
                NEXT: begin
                    if (address == LAST_ADDR) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        address       <= address + NB_ADDR'(1);
                        state         <= READ;
                        o_read_enable <= 1'b1;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_data_memory_dump_unit
//
// Directed bench for data_memory_dump_unit.
//   dut1: default parameters, with a 32-word memory model and a UART responder
//         whose latency and spurious tx_done injection can be set.
//   dut2: RAM_DEPTH=4, NB_DATA=16, with a fixed one-cycle UART responder.
// Outputs are sampled on the falling edge, and inputs are driven there too.
// -----------------------------------------------------------------------------
module tb_data_memory_dump_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic i_reset;

    // ---------------- dut1 (defaults) ----------------
    logic        i_start1, o_read_enable1, o_tx_start1, i_tx_done1, o_busy1, o_done1;
    logic [31:0] o_read_address1, i_mem_data1;
    logic [7:0]  o_tx_data1;
    logic [31:0] mem1 [32];

    data_memory_dump_unit dut1 (
        .i_clock        (clock),
        .i_reset        (i_reset),
        .i_start        (i_start1),
        .o_read_enable  (o_read_enable1),
        .o_read_address (o_read_address1),
        .i_mem_data     (i_mem_data1),
        .o_tx_data      (o_tx_data1),
        .o_tx_start     (o_tx_start1),
        .i_tx_done      (i_tx_done1),
        .o_busy         (o_busy1),
        .o_done         (o_done1)
    );

    always_comb begin
        i_mem_data1 = '0;
        if (o_read_address1 < 32) i_mem_data1 = mem1[o_read_address1[4:0]];
    end

    // ---------------- dut2 (4 x 16-bit) ----------------
    logic        i_start2, o_read_enable2, o_tx_start2, o_busy2, o_done2;
    logic        i_tx_done2 = 1'b0;
    logic [31:0] o_read_address2;
    logic [15:0] i_mem_data2;
    logic [7:0]  o_tx_data2;
    logic [15:0] mem2 [4];

    data_memory_dump_unit #(
        .NB_ADDR   (32),
        .NB_DATA   (16),
        .RAM_DEPTH (4),
        .NB_BYTE   (8)
    ) dut2 (
        .i_clock        (clock),
        .i_reset        (i_reset),
        .i_start        (i_start2),
        .o_read_enable  (o_read_enable2),
        .o_read_address (o_read_address2),
        .i_mem_data     (i_mem_data2),
        .o_tx_data      (o_tx_data2),
        .o_tx_start     (o_tx_start2),
        .i_tx_done      (i_tx_done2),
        .o_busy         (o_busy2),
        .o_done         (o_done2)
    );

    always_comb begin
        i_mem_data2 = '0;
        if (o_read_address2 < 4) i_mem_data2 = mem2[o_read_address2[1:0]];
    end

    // ---------------- UART responder for dut1 ----------------
    // tx_done arrives W cycles after the SEND cycle (W=1: in the first WAIT
    // cycle). With injection enabled, extra pulses are added during READ,
    // SEND and the cycle right after a real done (SEND or NEXT).
    bit lat_random = 1'b0;
    int lat_fixed  = 1;
    bit inject     = 1'b0;
    int remaining  = 0;
    bit prev_real  = 1'b0;
    bit real_done;

    always @(negedge clock) begin
        real_done = 1'b0;
        if (i_reset) begin
            remaining  = 0;
            prev_real  = 1'b0;
            i_tx_done1 = 1'b0;
        end else begin
            if (remaining > 0) begin
                remaining = remaining - 1;
                real_done = (remaining == 0);
            end
            if (o_tx_start1) remaining = lat_random ? int'($urandom_range(20, 1)) : lat_fixed;
            i_tx_done1 = real_done || (inject && (o_read_enable1 || o_tx_start1 || prev_real));
            prev_real  = real_done;
        end
    end

    // ---------------- UART responder for dut2 (W=1) ----------------
    bit prev_start2 = 1'b0;
    always @(negedge clock) begin
        i_tx_done2  = prev_start2;
        prev_start2 = o_tx_start2;
    end

    // ---------------- monitors ----------------
    logic [7:0]  q1 [$];
    logic [31:0] a1 [$];
    int done1_cnt = 0, done1_cyc = 0, re1_cnt = 0, start_viol = 0;
    bit prev_tx_start1 = 1'b0;

    always @(negedge clock) begin
        if (o_tx_start1) begin
            q1.push_back(o_tx_data1);
            a1.push_back(o_read_address1);
        end
        if (o_tx_start1 && prev_tx_start1) start_viol = start_viol + 1;
        prev_tx_start1 = o_tx_start1;
        if (o_read_enable1) re1_cnt = re1_cnt + 1;
        if (o_done1) begin
            done1_cnt = done1_cnt + 1;
            done1_cyc = cyc;
        end
    end

    logic [7:0] q2 [$];
    int done2_cnt = 0, done2_cyc = 0;
    logic [31:0] max_addr2 = '0;

    always @(negedge clock) begin
        if (o_tx_start2) q2.push_back(o_tx_data2);
        if (o_busy2 && o_read_address2 > max_addr2) max_addr2 = o_read_address2;
        if (o_done2) begin
            done2_cnt = done2_cnt + 1;
            done2_cyc = cyc;
        end
    end

    // ---------------- checking helpers ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon1();
        q1.delete();
        a1.delete();
        done1_cnt = 0;
        re1_cnt   = 0;
        start_viol = 0;
    endtask

    // Expected stream for dut1: word i is i*0x01010101, so its four bytes
    // all equal i. Word 0 is optionally DEADBEEF. Each byte is tagged with
    // the address of the word it belongs to.
    task automatic check_stream(input string tag, input bit first_dead);
        logic [31:0] dead;
        logic [7:0]  exp_byte;
        dead = 32'hDEADBEEF;
        check({tag, "_len"}, q1.size(), 128);
        for (int i = 0; i < q1.size() && i < 128; i++) begin
            exp_byte = (first_dead && i < 4) ? dead[31 - 8*i -: 8] : 8'(i / 4);
            check($sformatf("%s_byte%0d", tag, i), q1[i], exp_byte);
            check($sformatf("%s_addr%0d", tag, i), a1[i], i / 4);
        end
    endtask

    // Waits for o_done1 within a cycle budget. It optionally pulses i_start1
    // during the dump, and leaves i_start1 low once DONE is seen.
    task automatic wait_done1(input string tag, input int budget, input bit spam);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (o_done1) begin
                seen     = 1'b1;
                i_start1 = 1'b0;
                break;
            end
            i_start1 = spam && (n % 37 == 5);
        end
        check({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic check_zero_outputs1(input string tag);
        check({tag, "_re"},    o_read_enable1,  0);
        check({tag, "_addr"},  o_read_address1, 0);
        check({tag, "_data"},  o_tx_data1,      0);
        check({tag, "_start"}, o_tx_start1,     0);
        check({tag, "_busy"},  o_busy1,         0);
        check({tag, "_done"},  o_done1,         0);
    endtask

    // ---------------- directed sequence ----------------
    int  t0;
    bit  found;
    logic [7:0] exp2 [8];

    initial begin
        i_reset  = 1'b1;
        i_start1 = 1'b0;
        i_start2 = 1'b0;
        for (int i = 0; i < 32; i++) mem1[i] = 32'(i) * 32'h0101_0101;
        mem1[0] = 32'hDEADBEEF;
        mem2[0] = 16'hA1B2; mem2[1] = 16'hC3D4; mem2[2] = 16'hE5F6; mem2[3] = 16'h0789;
        exp2[0] = 8'hA1; exp2[1] = 8'hB2; exp2[2] = 8'hC3; exp2[3] = 8'hD4;
        exp2[4] = 8'hE5; exp2[5] = 8'hF6; exp2[6] = 8'h07; exp2[7] = 8'h89;

        // Reset state.
        repeat (3) @(negedge clock);
        check_zero_outputs1("rst");
        check("rst_busy2", o_busy2, 0);
        i_reset = 1'b0;
        @(negedge clock);
        check_zero_outputs1("idle");

        // A: DEADBEEF first word, W=1, timing of the full sweep.
        clear_mon1();
        t0 = cyc;
        i_start1 = 1'b1;
        @(negedge clock);
        i_start1 = 1'b0;
        check("a_read_busy", o_busy1, 1);
        check("a_read_re",   o_read_enable1, 1);
        check("a_read_addr", o_read_address1, 0);
        check("a_read_txs",  o_tx_start1, 0);
        wait_done1("a", 2000, 1'b0);
        @(negedge clock);
        check("a_busy_after", o_busy1, 0);
        check("a_done_cnt",   done1_cnt, 1);
        check("a_done_cycle", done1_cyc - t0, 321);
        check("a_re_cycles",  re1_cnt, 32);
        check("a_txs_b2b",    start_viol, 0);
        check_stream("a", 1'b1);

        // B: random latency, spurious tx_done, and repeated i_start during the dump.
        mem1[0]    = 32'h0;
        lat_random = 1'b1;
        inject     = 1'b1;
        clear_mon1();
        i_start1 = 1'b1;
        @(negedge clock);
        i_start1 = 1'b0;
        wait_done1("b", 6000, 1'b1);
        @(negedge clock);
        check("b_busy_after", o_busy1, 0);
        check("b_done_cnt",   done1_cnt, 1);
        check("b_txs_b2b",    start_viol, 0);
        check_stream("b", 1'b0);

        // C: i_start in the first IDLE cycle after DONE starts a new dump from 0.
        lat_random = 1'b0;
        inject     = 1'b0;
        clear_mon1();
        i_start1 = 1'b1;
        @(negedge clock);
        i_start1 = 1'b0;
        check("c_read_re",   o_read_enable1, 1);
        check("c_read_addr", o_read_address1, 0);
        wait_done1("c", 2000, 1'b0);
        @(negedge clock);
        check("c_done_cnt", done1_cnt, 1);
        check_stream("c", 1'b0);

        // D: reset in WAIT at address 5 aborts the dump without o_done.
        clear_mon1();
        i_start1 = 1'b1;
        @(negedge clock);
        i_start1 = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (o_tx_start1 && o_read_address1 == 32'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("d_reached_addr5", found, 1);
        @(negedge clock);
        check("d_wait_txs",  o_tx_start1, 0);
        check("d_wait_busy", o_busy1, 1);
        check("d_wait_addr", o_read_address1, 5);
        i_reset = 1'b1;
        @(negedge clock);
        check_zero_outputs1("d_rst");
        i_reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("d_idle_busy", o_busy1, 0);
        check("d_no_done",   done1_cnt, 0);

        // E: dump after the abort restarts from address 0.
        clear_mon1();
        i_start1 = 1'b1;
        @(negedge clock);
        i_start1 = 1'b0;
        check("e_read_addr", o_read_address1, 0);
        wait_done1("e", 2000, 1'b0);
        @(negedge clock);
        check("e_done_cnt", done1_cnt, 1);
        check_stream("e", 1'b0);

        // F: RAM_DEPTH=4, NB_DATA=16 -> 8 bytes MSB first, stops at address 3.
        q2.delete();
        done2_cnt = 0;
        max_addr2 = '0;
        t0 = cyc;
        i_start2 = 1'b1;
        @(negedge clock);
        i_start2 = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (o_done2) begin
                found = 1'b1;
                break;
            end
        end
        check("f_done_seen", found, 1);
        @(negedge clock);
        check("f_busy_after", o_busy2, 0);
        check("f_done_cnt",   done2_cnt, 1);
        check("f_done_cycle", done2_cyc - t0, 25);
        check("f_max_addr",   max_addr2, 3);
        check("f_addr_final", o_read_address2, 3);
        check("f_len",        q2.size(), 8);
        for (int i = 0; i < q2.size() && i < 8; i++)
            check($sformatf("f_byte%0d", i), q2[i], exp2[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
